// File: rtl/ddc_cfg_arbiter.sv
// Two-port round-robin arbiter funnelling register commands onto one AXI4-Lite master.
// Optional watchdog on transaction length is enabled by defining DDC_CFG_ARB_TIMEOUT_EN.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a requester, grants one per command
// WR    | AW and W offered, each dropped on its handshake
// WB    | waiting for the write response
// RA    | AR offered until accepted
// RD    | waiting for the read data
module ddc_cfg_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            req0_valid,
  output logic                            req0_ready,
  input  logic                            req0_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
  output logic                            req0_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,
  output logic [1:0]                      req0_resp,
  input  logic                            req1_valid,
  output logic                            req1_ready,
  input  logic                            req1_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
  output logic                            req1_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,
  output logic [1:0]                      req1_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic                            timeout_flag
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_RA   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;

  logic [2:0]                    state;
  logic                          rr_ptr;
  logic                          gnt;
  logic                          sel;
  logic                          grant_en;
  logic                          g_we;
  logic [C_M_AXI_ADDR_WIDTH-1:0] g_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] g_wdata;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic                          awvalid_q;
  logic                          wvalid_q;
  logic                          arvalid_q;

  // rr_ptr names the port that wins a tie; a lone requester always wins
  assign sel      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
  assign grant_en = (state == S_IDLE) && !ARESET && !req0_done && !req1_done &&
                    (req0_valid || req1_valid);
  assign req0_ready = grant_en && !sel;
  assign req1_ready = grant_en && sel;
  assign g_we    = sel ? req1_we    : req0_we;
  assign g_addr  = sel ? req1_addr  : req0_addr;
  assign g_wdata = sel ? req1_wdata : req0_wdata;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_BREADY  = (state == S_WB);
  assign M_AXI_RREADY  = (state == S_RD);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      gnt        <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      req0_resp  <= 2'b00;
      req1_resp  <= 2'b00;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            gnt     <= sel;
            rr_ptr  <= ~sel;
            addr_q  <= g_addr;
            wdata_q <= g_wdata;
            if (g_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= S_WR;
            end else begin
              arvalid_q <= 1'b1;
              state     <= S_RA;
            end
          end
        end
        S_WR: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          // AW and W may complete in either order; leave once both are done
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY))
            state <= S_WB;
        end
        S_WB: begin
          if (M_AXI_BVALID) begin
            if (gnt) begin
              req1_resp <= M_AXI_BRESP;
              req1_done <= 1'b1;
            end else begin
              req0_resp <= M_AXI_BRESP;
              req0_done <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        S_RA: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            state     <= S_RD;
          end
        end
        S_RD: begin
          if (M_AXI_RVALID) begin
            if (gnt) begin
              req1_rdata <= M_AXI_RDATA;
              req1_resp  <= M_AXI_RRESP;
              req1_done  <= 1'b1;
            end else begin
              req0_rdata <= M_AXI_RDATA;
              req0_resp  <= M_AXI_RRESP;
              req0_done  <= 1'b1;
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DDC_CFG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic             to_flag;

  // counter saturates at the limit; the flag only reports, it never aborts
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (grant_en) begin
      to_cnt <= '0;
    end else if (state != S_IDLE) begin
      if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 1'b1;
      else                    to_flag <= 1'b1;
    end
  end

  assign timeout_flag = to_flag;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: doc/ddc_cfg_arbiter.md
DDC_CFG_ARBITER -- requirements
Module: ddc_cfg_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width, fixed at 32.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit; used only when DDC_CFG_ARB_TIMEOUT_EN is defined.
REQ-004 ACLK  in  1  the single clock; all logic is on its rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) command valid.
REQ-007 reqN_ready  out  1  command accepted this cycle.
REQ-008 reqN_we  in  1  1=write, 0=read.
REQ-009 reqN_addr  in  ADDR_WIDTH  register byte address.
REQ-010 reqN_wdata  in  32  write data.
REQ-011 reqN_done  out  1  one-cycle completion pulse.
REQ-012 reqN_rdata  out  32  read data, valid with reqN_done and held until the next completion on that port.
REQ-013 reqN_resp  out  2  AXI response, valid with reqN_done and held until the next completion on that port.
REQ-014 M_AXI_* out/in: AWADDR, AWPROT(=000), AWVALID, AWREADY, WDATA, WSTRB(=1111), WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT(=000), ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY; standard AXI4-Lite master.
REQ-015 timeout_flag  out  1  sticky watchdog flag; constant 0 when the macro is undefined.

Function
REQ-016 SHALL hold exactly one outstanding AXI transaction at a time.
REQ-017 FSM states: IDLE, WR (AW/W issue), WB (await B), RA (AR issue), RD (await R).
REQ-018 In IDLE with any reqN_valid, SHALL grant one requester, pulse its reqN_ready for one cycle, and register addr/wdata/we.
REQ-019 Next state after grant: WR if we=1, RA if we=0.
REQ-020 Arbitration SHALL be round-robin: on simultaneous valid, grant the port not granted last; after reset, port 0 has priority.
REQ-021 WR SHALL assert AWVALID and WVALID together in the cycle after the grant.
REQ-022 WR SHALL deassert each of AWVALID and WVALID independently on its own handshake, and go to WB once both handshakes have occurred (same cycle or different cycles).
REQ-023 WB SHALL hold BREADY=1; on BVALID it SHALL capture BRESP, pulse the granted port's done in the next cycle, and return to IDLE.
REQ-024 RA SHALL assert ARVALID until ARREADY, then go to RD.
REQ-025 RD SHALL hold RREADY=1; on RVALID it SHALL capture RDATA and RRESP, pulse done in the next cycle, and return to IDLE.
REQ-026 SHALL not grant while done is pulsing; minimum spacing between grants is 2 cycles plus slave latency.
REQ-027 A non-granted requester's valid SHALL be ignored until IDLE; its inputs need not stay stable while unready.
REQ-028 Address, data and control SHALL stay stable while any AXI VALID is high and unaccepted.
REQ-029 BREADY and RREADY SHALL be 0 outside WB and RD respectively.

Reset
REQ-030 While ARESET=1 (sampled), the FSM SHALL go to IDLE.
REQ-031 While ARESET=1, all VALID/READY outputs, reqN_ready, reqN_done, rdata, resp and timeout_flag SHALL be 0, and the round-robin pointer SHALL select port 0.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no done pulse; the slave is assumed reset by the same signal.

Configuration
REQ-033 The macro DDC_CFG_ARB_TIMEOUT_EN, when defined, SHALL enable a counter that clears on entry to WR/RA and increments each cycle spent in WR, WB, RA or RD.
REQ-034 With the macro defined, when the counter reaches TIMEOUT_CYCLES it SHALL set timeout_flag (sticky until ARESET), and the transaction SHALL continue waiting with no abort.
REQ-035 With the macro undefined, the block SHALL contain no counter and timeout_flag SHALL be tied to 0.

Verification
REQ-036 Port 0 writes 0x00000001 to addr 0x0, slave with zero-wait ready -> one AW/W beat with WSTRB=1111, req0_done 1 cycle after BVALID, req0_resp=00.
REQ-037 Write 0x1..0x4 to addrs 0x0..0xC, then read them back -> req_rdata matches each written value, resp=00.
REQ-038 Both ports valid every cycle for 4 grants -> grant order 0,1,0,1; no overlapping AXI transactions.
REQ-039 Slave accepts AW 3 cycles before W -> AWVALID drops after AWREADY, WVALID holds until WREADY, exactly one B accepted.
REQ-040 Slave returns RRESP=10 with RDATA=0xDEADBEEF -> reqN_rdata=0xDEADBEEF, reqN_resp=10.
REQ-041 With the macro defined and TIMEOUT_CYCLES=16, slave withholds BVALID for 20 cycles -> timeout_flag=1 from cycle 16 on; done still pulses after BVALID. Assert ARESET mid-RD -> all outputs 0, no done pulse.
